// File: rtl/int_regstat_if.sv
// Issue/commit/read bundle between the issue stage and the integer register
// status table. The table side uses the slave modport.
interface int_regstat_if #(
  parameter int REG_IDX_LEN = 5,
  parameter int ROB_IDX_LEN = 6
);
  logic                   flush_i;
  logic                   issue_valid_i;
  logic                   issue_ready_o;
  logic [REG_IDX_LEN-1:0] issue_rd_idx_i;
  logic [ROB_IDX_LEN-1:0] issue_rob_idx_i;
  logic [REG_IDX_LEN-1:0] issue_rs1_idx_i;
  logic [REG_IDX_LEN-1:0] issue_rs2_idx_i;
  logic                   issue_rs1_busy_o;
  logic [ROB_IDX_LEN-1:0] issue_rs1_rob_o;
  logic                   issue_rs2_busy_o;
  logic [ROB_IDX_LEN-1:0] issue_rs2_rob_o;
  logic                   comm_valid_i;
  logic [REG_IDX_LEN-1:0] comm_rd_idx_i;

  modport slave (
    input  flush_i, issue_valid_i, issue_rd_idx_i, issue_rob_idx_i,
           issue_rs1_idx_i, issue_rs2_idx_i, comm_valid_i, comm_rd_idx_i,
    output issue_ready_o, issue_rs1_busy_o, issue_rs1_rob_o,
           issue_rs2_busy_o, issue_rs2_rob_o
  );

  modport master (
    output flush_i, issue_valid_i, issue_rd_idx_i, issue_rob_idx_i,
           issue_rs1_idx_i, issue_rs2_idx_i, comm_valid_i, comm_rd_idx_i,
    input  issue_ready_o, issue_rs1_busy_o, issue_rs1_rob_o,
           issue_rs2_busy_o, issue_rs2_rob_o
  );
endinterface

// File: rtl/int_regstat.sv
// Integer register status table: per architectural register, a count of
// in-flight writers and the ROB index of the youngest one. Source reads are
// combinational; x0 carries no state.
// Optional build macro INT_REGSTAT_COMM_BYPASS_EN: a source whose last
// pending writer commits this cycle reads as not busy.

// Flags a commit to a register that has no pending writer.
module int_regstat_chk (
  input logic clk_i,
  input logic rst_n_i,
  input logic flush_i,
  input logic comm_fire_i,
  input logic comm_cnt_zero_i
);
  // A counted-down-to-zero register must never see another commit.
  a_no_commit_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_n_i || flush_i)
      !(comm_fire_i && comm_cnt_zero_i)
  ) else $error("int_regstat: commit to register with no pending writer");
endmodule

module int_regstat #(
  parameter int XREG_NUM    = 32,
  parameter int REG_IDX_LEN = 5,
  parameter int ROB_IDX_LEN = 6,
  parameter int BUSY_CNT_W  = 3
) (
  input logic          clk_i,
  input logic          rst_n_i,
  int_regstat_if.slave bus
);

  localparam logic [BUSY_CNT_W-1:0]  CNT_ZERO = {BUSY_CNT_W{1'b0}};
  localparam logic [BUSY_CNT_W-1:0]  CNT_ONE  = {{(BUSY_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BUSY_CNT_W-1:0]  CNT_MAX  = {BUSY_CNT_W{1'b1}};
  localparam logic [ROB_IDX_LEN-1:0] ROB_ZERO = {ROB_IDX_LEN{1'b0}};
  localparam logic [REG_IDX_LEN-1:0] IDX_ZERO = {REG_IDX_LEN{1'b0}};

  // Per-register state; x0 is deliberately absent.
  logic [BUSY_CNT_W-1:0]  cnt_r [1:XREG_NUM-1];
  logic [ROB_IDX_LEN-1:0] rob_r [1:XREG_NUM-1];

  logic [BUSY_CNT_W-1:0]  rs1_cnt_s;
  logic [BUSY_CNT_W-1:0]  rs2_cnt_s;
  logic [BUSY_CNT_W-1:0]  rd_cnt_s;
  logic [BUSY_CNT_W-1:0]  comm_cnt_s;
  logic [ROB_IDX_LEN-1:0] rs1_rob_s;
  logic [ROB_IDX_LEN-1:0] rs2_rob_s;
  logic                   ready_s;
  logic                   issue_fire_s;
  logic                   comm_fire_s;
  logic                   rs1_byp_s;
  logic                   rs2_byp_s;
  logic [XREG_NUM-1:1]    inc_s;
  logic [XREG_NUM-1:1]    dec_s;

  // Look up the addressed registers; index 0 falls through to the zero default.
  always_comb begin
    rs1_cnt_s  = CNT_ZERO;
    rs2_cnt_s  = CNT_ZERO;
    rd_cnt_s   = CNT_ZERO;
    comm_cnt_s = CNT_ZERO;
    rs1_rob_s  = ROB_ZERO;
    rs2_rob_s  = ROB_ZERO;
    for (int r = 1; r < XREG_NUM; r++) begin
      rs1_cnt_s  = (bus.issue_rs1_idx_i == REG_IDX_LEN'(r)) ? cnt_r[r] : rs1_cnt_s;
      rs1_rob_s  = (bus.issue_rs1_idx_i == REG_IDX_LEN'(r)) ? rob_r[r] : rs1_rob_s;
      rs2_cnt_s  = (bus.issue_rs2_idx_i == REG_IDX_LEN'(r)) ? cnt_r[r] : rs2_cnt_s;
      rs2_rob_s  = (bus.issue_rs2_idx_i == REG_IDX_LEN'(r)) ? rob_r[r] : rs2_rob_s;
      rd_cnt_s   = (bus.issue_rd_idx_i  == REG_IDX_LEN'(r)) ? cnt_r[r] : rd_cnt_s;
      comm_cnt_s = (bus.comm_rd_idx_i   == REG_IDX_LEN'(r)) ? cnt_r[r] : comm_cnt_s;
    end
  end

  // Stall only when the destination counter is already saturated; the
  // same-cycle commit is intentionally ignored to keep this path short.
  always_comb begin
    ready_s      = !(bus.issue_valid_i && (bus.issue_rd_idx_i != IDX_ZERO) &&
                     (rd_cnt_s == CNT_MAX));
    issue_fire_s = bus.issue_valid_i && ready_s && (bus.issue_rd_idx_i != IDX_ZERO);
    comm_fire_s  = bus.comm_valid_i && (bus.comm_rd_idx_i != IDX_ZERO);
  end

  // Per-register increment/decrement requests; a decrement at zero is dropped.
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int r = 1; r < XREG_NUM; r++) begin
      inc_s[r] = issue_fire_s && (bus.issue_rd_idx_i == REG_IDX_LEN'(r));
      dec_s[r] = comm_fire_s && (bus.comm_rd_idx_i == REG_IDX_LEN'(r)) &&
                 (cnt_r[r] != CNT_ZERO);
    end
  end

  // Commit bypass: the last pending writer retiring now makes the source ready.
  always_comb begin
    rs1_byp_s = 1'b0;
    rs2_byp_s = 1'b0;
`ifdef INT_REGSTAT_COMM_BYPASS_EN
    rs1_byp_s = comm_fire_s && (bus.comm_rd_idx_i == bus.issue_rs1_idx_i) &&
                (rs1_cnt_s == CNT_ONE) &&
                !(issue_fire_s && (bus.issue_rd_idx_i == bus.issue_rs1_idx_i));
    rs2_byp_s = comm_fire_s && (bus.comm_rd_idx_i == bus.issue_rs2_idx_i) &&
                (rs2_cnt_s == CNT_ONE) &&
                !(issue_fire_s && (bus.issue_rd_idx_i == bus.issue_rs2_idx_i));
`else
    rs1_byp_s = 1'b0;
    rs2_byp_s = 1'b0;
`endif
  end

  // Counter and youngest-writer update: reset > flush > issue/commit.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int r = 1; r < XREG_NUM; r++) begin
        cnt_r[r] <= CNT_ZERO;
        rob_r[r] <= ROB_ZERO;
      end
    end else if (bus.flush_i) begin
      for (int r = 1; r < XREG_NUM; r++) begin
        cnt_r[r] <= CNT_ZERO;
        rob_r[r] <= rob_r[r];
      end
    end else begin
      for (int r = 1; r < XREG_NUM; r++) begin
        case ({inc_s[r], dec_s[r]})
          2'b10:   cnt_r[r] <= cnt_r[r] + CNT_ONE;
          2'b01:   cnt_r[r] <= cnt_r[r] - CNT_ONE;
          default: cnt_r[r] <= cnt_r[r];
        endcase
        if (inc_s[r]) begin
          rob_r[r] <= bus.issue_rob_idx_i;
        end else begin
          rob_r[r] <= rob_r[r];
        end
      end
    end
  end

  assign bus.issue_ready_o    = ready_s;
  assign bus.issue_rs1_busy_o = (rs1_cnt_s != CNT_ZERO) && !rs1_byp_s;
  assign bus.issue_rs1_rob_o  = rs1_rob_s;
  assign bus.issue_rs2_busy_o = (rs2_cnt_s != CNT_ZERO) && !rs2_byp_s;
  assign bus.issue_rs2_rob_o  = rs2_rob_s;

  int_regstat_chk u_chk (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .flush_i         (bus.flush_i),
    .comm_fire_i     (comm_fire_s),
    .comm_cnt_zero_i (comm_cnt_s == CNT_ZERO)
  );

endmodule

// File: tb/tb_int_regstat.sv
// Self-checking bench for int_regstat: directed scenarios plus a randomized
// run against a behavioural per-register counter model.
module tb_int_regstat;

`ifdef INT_REGSTAT_COMM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXC = 7;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  int          m_cnt [32];
  logic [5:0]  m_rob [32];

  int_regstat_if #(.REG_IDX_LEN(5), .ROB_IDX_LEN(6)) bus ();

  int_regstat dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected ready from the current request and model counts.
  function automatic bit exp_ready();
    int rd;
    rd = int'(bus.issue_rd_idx_i);
    return !(bus.issue_valid_i && rd != 0 && m_cnt[rd] == MAXC);
  endfunction

  // Expected busy for a source, including the optional commit bypass.
  function automatic bit exp_busy(int rs);
    bit iss_same;
    bit byp;
    int rd;
    rd = int'(bus.issue_rd_idx_i);
    iss_same = bus.issue_valid_i && rd != 0 && m_cnt[rd] < MAXC && rd == rs;
    byp = BYP && bus.comm_valid_i && rs != 0 && int'(bus.comm_rd_idx_i) == rs &&
          m_cnt[rs] == 1 && !iss_same;
    return (rs != 0) && (m_cnt[rs] != 0) && !byp;
  endfunction

  function automatic logic [5:0] exp_rob(int rs);
    return (rs == 0) ? 6'd0 : m_rob[rs];
  endfunction

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    int  rd;
    int  crd;
    bit  iss;
    bit  com;
    rd  = int'(bus.issue_rd_idx_i);
    crd = int'(bus.comm_rd_idx_i);
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_cnt[r] = 0;
        m_rob[r] = 6'd0;
      end
    end else if (bus.flush_i) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else begin
      iss = bus.issue_valid_i && rd != 0 && m_cnt[rd] < MAXC;
      com = bus.comm_valid_i && crd != 0 && m_cnt[crd] > 0;
      if (com) m_cnt[crd] = m_cnt[crd] - 1;
      if (iss) begin
        m_cnt[rd] = m_cnt[rd] + 1;
        m_rob[rd] = bus.issue_rob_idx_i;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i         = 1'b0;
    bus.issue_valid_i   = 1'b0;
    bus.issue_rd_idx_i  = 5'd0;
    bus.issue_rob_idx_i = 6'd0;
    bus.comm_valid_i    = 1'b0;
    bus.comm_rd_idx_i   = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [5:0] rob);
    bus.issue_valid_i   = 1'b1;
    bus.issue_rd_idx_i  = rd;
    bus.issue_rob_idx_i = rob;
  endtask

  task automatic commit(input logic [4:0] rd);
    bus.comm_valid_i  = 1'b1;
    bus.comm_rd_idx_i = rd;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    bus.issue_rs1_idx_i = 5'd0;
    bus.issue_rs2_idx_i = 5'd0;
    tick();
    tick();
    rst_n = 1'b1;
    bus.issue_rs1_idx_i = 5'd5;
    bus.issue_rs2_idx_i = 5'd0;
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", bus.issue_rs1_busy_o); end
    checks++; if (bus.issue_rs2_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy2 got=%b exp=0", bus.issue_rs2_busy_o); end
    checks++; if (bus.issue_rs1_rob_o !== 6'd0) begin errors++; $display("FAIL reset_rob1 got=%0d exp=0", bus.issue_rs1_rob_o); end
    checks++; if (bus.issue_rs2_rob_o !== 6'd0) begin errors++; $display("FAIL reset_rob2 got=%0d exp=0", bus.issue_rs2_rob_o); end
    checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.issue_ready_o); end
  endtask

  task automatic test_issue_commit();
    idle();
    issue(5'd5, 6'd12);
    tick();
    idle();
    bus.issue_rs1_idx_i = 5'd5;
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b1) begin errors++; $display("FAIL ic_busy got=%b exp=1", bus.issue_rs1_busy_o); end
    checks++; if (bus.issue_rs1_rob_o !== 6'd12) begin errors++; $display("FAIL ic_rob got=%0d exp=12", bus.issue_rs1_rob_o); end
    commit(5'd5);
    #1;
    checks++; if (bus.issue_rs1_busy_o !== !BYP) begin errors++; $display("FAIL ic_commit_cycle_busy got=%b exp=%b", bus.issue_rs1_busy_o, !BYP); end
    tick();
    idle();
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b0) begin errors++; $display("FAIL ic_after_commit_busy got=%b exp=0", bus.issue_rs1_busy_o); end
    checks++; if (bus.issue_rs1_rob_o !== 6'd12) begin errors++; $display("FAIL ic_rob_kept got=%0d exp=12", bus.issue_rs1_rob_o); end
  endtask

  task automatic test_saturation();
    idle();
    bus.issue_rs1_idx_i = 5'd3;
    for (int k = 1; k <= 7; k++) begin
      issue(5'd3, 6'(k));
      #1;
      checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL sat_ready_%0d got=%b exp=1", k, bus.issue_ready_o); end
      tick();
    end
    issue(5'd3, 6'd8);
    #1;
    checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL sat_stall got=%b exp=0", bus.issue_ready_o); end
    tick();
    checks++; if (bus.issue_rs1_rob_o !== 6'd7) begin errors++; $display("FAIL sat_rob_hold got=%0d exp=7", bus.issue_rs1_rob_o); end
    commit(5'd3);
    #1;
    checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL sat_stall_with_commit got=%b exp=0", bus.issue_ready_o); end
    tick();
    bus.comm_valid_i = 1'b0;
    #1;
    checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL sat_ready_after_commit got=%b exp=1", bus.issue_ready_o); end
    idle();
    for (int k = 0; k < 6; k++) begin
      commit(5'd3);
      tick();
    end
    idle();
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b0) begin errors++; $display("FAIL sat_drained_busy got=%b exp=0", bus.issue_rs1_busy_o); end
  endtask

  task automatic test_same_reg();
    idle();
    issue(5'd7, 6'd4);
    tick();
    idle();
    bus.issue_rs1_idx_i = 5'd7;
    issue(5'd7, 6'd9);
    commit(5'd7);
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b1) begin errors++; $display("FAIL same_cycle_busy got=%b exp=1", bus.issue_rs1_busy_o); end
    checks++; if (bus.issue_rs1_rob_o !== 6'd4) begin errors++; $display("FAIL same_cycle_old_rob got=%0d exp=4", bus.issue_rs1_rob_o); end
    tick();
    idle();
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b1) begin errors++; $display("FAIL same_next_busy got=%b exp=1", bus.issue_rs1_busy_o); end
    checks++; if (bus.issue_rs1_rob_o !== 6'd9) begin errors++; $display("FAIL same_next_rob got=%0d exp=9", bus.issue_rs1_rob_o); end
    commit(5'd7);
    tick();
    idle();
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b0) begin errors++; $display("FAIL same_cnt_one got=%b exp=0", bus.issue_rs1_busy_o); end
  endtask

  task automatic test_flush();
    idle();
    issue(5'd1, 6'd11); tick();
    issue(5'd2, 6'd22); tick();
    issue(5'd4, 6'd44); tick();
    idle();
    bus.flush_i = 1'b1;
    issue(5'd8, 6'd5);
    commit(5'd1);
    #1;
    checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", bus.issue_ready_o); end
    tick();
    idle();
    bus.issue_rs1_idx_i = 5'd1;
    bus.issue_rs2_idx_i = 5'd2;
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy_x1 got=%b exp=0", bus.issue_rs1_busy_o); end
    checks++; if (bus.issue_rs2_busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy_x2 got=%b exp=0", bus.issue_rs2_busy_o); end
    bus.issue_rs1_idx_i = 5'd4;
    bus.issue_rs2_idx_i = 5'd8;
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy_x4 got=%b exp=0", bus.issue_rs1_busy_o); end
    checks++; if (bus.issue_rs1_rob_o !== 6'd44) begin errors++; $display("FAIL flush_rob_kept got=%0d exp=44", bus.issue_rs1_rob_o); end
    checks++; if (bus.issue_rs2_busy_o !== 1'b0) begin errors++; $display("FAIL flush_x8_busy got=%b exp=0", bus.issue_rs2_busy_o); end
    checks++; if (bus.issue_rs2_rob_o !== 6'd0) begin errors++; $display("FAIL flush_x8_rob got=%0d exp=0", bus.issue_rs2_rob_o); end
  endtask

  task automatic test_bypass();
    idle();
    issue(5'd10, 6'd3);
    tick();
    idle();
    bus.issue_rs1_idx_i = 5'd10;
    bus.issue_rs2_idx_i = 5'd10;
    commit(5'd10);
    #1;
    checks++; if (bus.issue_rs1_busy_o !== !BYP) begin errors++; $display("FAIL bypass_rs1 got=%b exp=%b", bus.issue_rs1_busy_o, !BYP); end
    checks++; if (bus.issue_rs2_busy_o !== !BYP) begin errors++; $display("FAIL bypass_rs2 got=%b exp=%b", bus.issue_rs2_busy_o, !BYP); end
    issue(5'd10, 6'd6);
    #1;
    checks++; if (bus.issue_rs1_busy_o !== 1'b1) begin errors++; $display("FAIL bypass_blocked_by_issue got=%b exp=1", bus.issue_rs1_busy_o); end
    tick();
    idle();
    commit(5'd10);
    tick();
    idle();
  endtask

  task automatic test_random();
    int crd;
    int rs1;
    int rs2;
    for (int i = 0; i < 600; i++) begin
      bus.flush_i         = ($urandom_range(0, 40) == 0);
      bus.issue_valid_i   = ($urandom_range(0, 3) != 0);
      bus.issue_rd_idx_i  = 5'($urandom_range(0, 6));
      bus.issue_rob_idx_i = 6'($urandom);
      crd = $urandom_range(0, 6);
      bus.comm_valid_i    = ($urandom_range(0, 1) == 1) && (m_cnt[crd] > 0);
      bus.comm_rd_idx_i   = 5'(crd);
      rs1 = $urandom_range(0, 8);
      rs2 = ($urandom_range(0, 3) == 0) ? int'(bus.issue_rd_idx_i) : $urandom_range(0, 8);
      bus.issue_rs1_idx_i = 5'(rs1);
      bus.issue_rs2_idx_i = 5'(rs2);
      #1;
      checks++; if (bus.issue_ready_o !== exp_ready()) begin errors++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, bus.issue_ready_o, exp_ready()); end
      checks++; if (bus.issue_rs1_busy_o !== exp_busy(rs1)) begin errors++; $display("FAIL rnd_busy1 i=%0d rs=%0d got=%b exp=%b", i, rs1, bus.issue_rs1_busy_o, exp_busy(rs1)); end
      checks++; if (bus.issue_rs2_busy_o !== exp_busy(rs2)) begin errors++; $display("FAIL rnd_busy2 i=%0d rs=%0d got=%b exp=%b", i, rs2, bus.issue_rs2_busy_o, exp_busy(rs2)); end
      checks++; if (bus.issue_rs1_rob_o !== exp_rob(rs1)) begin errors++; $display("FAIL rnd_rob1 i=%0d rs=%0d got=%0d exp=%0d", i, rs1, bus.issue_rs1_rob_o, exp_rob(rs1)); end
      checks++; if (bus.issue_rs2_rob_o !== exp_rob(rs2)) begin errors++; $display("FAIL rnd_rob2 i=%0d rs=%0d got=%0d exp=%0d", i, rs2, bus.issue_rs2_rob_o, exp_rob(rs2)); end
      tick();
    end
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.issue_rs1_idx_i = 5'd0;
    bus.issue_rs2_idx_i = 5'd0;
    idle();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0;
      m_rob[r] = 6'd0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_issue_commit();
    test_saturation();
    test_same_reg();
    test_flush();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
